uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Sequencing FSM for the UART receiver. It detects the start of a frame on the serial line and runs the oversampling edge and bit counters. It pulses the enables of the RX sub-blocks (data sampler, deserializer, start/parity/stop checkers) at the correct oversample edge. It aborts on glitch or error and flags a completed good frame with a one-cycle data_valid.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first)
PRESCALE_W, 6, width of prescale and edge_cnt

Ports:
clk  input  1  system (RX) clock
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  synchronized serial line, idle high
par_en  input  1  1 = frame carries a parity bit
prescale  input  PRESCALE_W  oversample ratio; legal values 8, 16, 32
start_glitch  input  1  start checker flag (1 = start bit sampled high)
par_err  input  1  parity checker error flag
stp_err  input  1  stop checker error flag
edge_cnt  output  PRESCALE_W  oversample edge index within current bit
bit_cnt  output  4  data bit index 0..DATA_WIDTH-1
dat_samp_en  output  1  data sampler enable
deser_en  output  1  deserializer shift strobe
strt_chk_en  output  1  start checker enable
par_chk_en  output  1  parity checker enable
stp_chk_en  output  1  stop checker enable
data_valid  output  1  one-cycle pulse: frame accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; latched prescale/par_en cleared. Reset mid-frame discards the frame; no enable or data_valid is produced.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Latching: prescale and par_en are captured on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Definitions: P = latched prescale. LAST = P-1. CHK = P/2+2, i.e. one edge after the sampler's 3-sample majority window (P/2-1, P/2, P/2+1) completes.
- IDLE: counters held 0. If rx_in=0, go to START; that detection cycle counts as edge 0, so edge_cnt=1 on entry.
- Counter rules outside IDLE:
  - edge_cnt increments every cycle and wraps LAST->0 at each bit boundary.
  - bit_cnt increments at each DATA-bit wrap and resets to 0 on leaving DATA.
- dat_samp_en=1 in every non-IDLE state.
- START: strt_chk_en=1 for the single cycle where edge_cnt==CHK. start_glitch is evaluated at edge_cnt==LAST:
  - start_glitch=1 -> IDLE.
  - start_glitch=0 -> DATA.
- DATA: deser_en=1 for the single cycle where edge_cnt==CHK, for each bit. At edge_cnt==LAST with bit_cnt==DATA_WIDTH-1:
  - par_en=1 -> PARITY.
  - par_en=0 -> STOP.
- PARITY: par_chk_en pulses at CHK. At LAST:
  - par_err=1 -> IDLE, no data_valid.
  - par_err=0 -> STOP.
- STOP: stp_chk_en pulses at CHK. At LAST:
  - stp_err=1 -> IDLE, no data_valid.
  - stp_err=0 -> IDLE and data_valid=1 for exactly one cycle (the first IDLE cycle).
- Frame length: (2+DATA_WIDTH+par_en)*P cycles from the rx_in falling edge to data_valid.
- Back-to-back frames: if rx_in=0 in the data_valid cycle, that cycle is edge 0 of the next START.
- Enables are mutually exclusive single-cycle pulses except dat_samp_en. No enable pulse is issued in IDLE.
- Illegal prescale values (not 8/16/32): behaviour unspecified. The bench must not drive them.
- Error flags are sampled only at LAST of their own state; their values at other times are ignored.

Test Plan:
- P=8, par_en=0, send 0xA5 clean -> 8 deser_en pulses at edge 6 of each bit, then stp_chk_en, then data_valid 80 cycles after the falling edge. No par_chk_en.
- P=16, par_en=1, send 0x3C with even parity, no errors -> par_chk_en at edge 10 of the parity bit; data_valid at cycle 176.
- P=8, rx_in low 3 cycles then high, start_glitch=1 at edge 7 -> strt_chk_en at edge 6; return to IDLE at edge 7; no deser_en, no data_valid.
- P=8, par_en=1, par_err=1 at parity LAST -> IDLE; no stp_chk_en, no data_valid. Repeat with stp_err=1 in STOP -> no data_valid.
- Two frames back-to-back (rx_in=0 in the data_valid cycle) with P=32 -> second START entered with edge_cnt=1. Two data_valid pulses 320 cycles apart.
- Mid-frame prescale change 8->16 during DATA -> the frame completes at P=8 timing. Assert rst_n=0 in bit 4 -> all outputs 0 immediately; after release, IDLE with no spurious pulses.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: frame detection, oversample edge/bit counting, sub-block enables.
// Latency: enables and data_valid are registered; data_valid arrives (2+DATA_WIDTH+par_en)*P cycles after the falling edge.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] ONE      = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  par_q, par_d;
    logic [PRESCALE_W-1:0] last_q;
    logic [PRESCALE_W-1:0] chk_d;
    logic                  samp_d, deser_d, strt_d, parc_d, stpc_d, dv_d;
    logic                  samp_q, deser_q, strt_q, parc_q, stpc_q, dv_q;

    assign last_q = p_q - ONE;
    // Check point sits one edge after the 3-sample majority window around P/2.
    assign chk_d  = (p_d >> 1) + ONE + ONE;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        p_d     = p_q;
        par_d   = par_q;
        dv_d    = 1'b0;
        if (state_q == IDLE) begin
            edge_d = '0;
            bit_d  = '0;
            if (!rx_in) begin
                // The detection cycle is edge 0 of the start bit.
                state_d = START;
                edge_d  = ONE;
                p_d     = prescale;
                par_d   = par_en;
            end
        end else if (edge_q == last_q) begin
            edge_d = '0;
            case (state_q)
                START:   state_d = start_glitch ? IDLE : DATA;
                DATA: begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
                PARITY:  state_d = par_err ? IDLE : STOP;
                STOP: begin
                    state_d = IDLE;
                    dv_d    = !stp_err;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            edge_d = edge_q + ONE;
        end

        samp_d  = (state_d != IDLE);
        strt_d  = (state_d == START)  && (edge_d == chk_d);
        deser_d = (state_d == DATA)   && (edge_d == chk_d);
        parc_d  = (state_d == PARITY) && (edge_d == chk_d);
        stpc_d  = (state_d == STOP)   && (edge_d == chk_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= '0;
            par_q   <= 1'b0;
            samp_q  <= 1'b0;
            deser_q <= 1'b0;
            strt_q  <= 1'b0;
            parc_q  <= 1'b0;
            stpc_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            par_q   <= par_d;
            samp_q  <= samp_d;
            deser_q <= deser_d;
            strt_q  <= strt_d;
            parc_q  <= parc_d;
            stpc_q  <= stpc_d;
            dv_q    <= dv_d;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = samp_q;
    assign deser_en    = deser_q;
    assign strt_chk_en = strt_q;
    assign par_chk_en  = parc_q;
    assign stp_chk_en  = stpc_q;
    assign data_valid  = dv_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of frame scenarios plus back-to-back and reset sequences.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in, par_en, start_glitch, par_err, stp_err;
    logic [5:0] prescale;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .start_glitch(start_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       p;
        bit       par;
        bit [7:0] data;
        int       glitch_len;
        bit       sg, perr, serr;
        int       pmid;
        int       e_strt, e_deser, e_par, e_stp, e_dv, e_dvcyc, e_samp;
    } vec_t;

    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;

    int n_strt, n_deser, n_par, n_stp, n_dv, n_samp, bad_pos, edge1, edge2;
    int dv_cyc[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int nfr);
        int F, N, cp;
        logic [10:0] bits;
        F  = (10 + int'(v.par)) * v.p;
        N  = nfr * F + 4 * v.p;
        cp = v.p / 2 + 2;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = v.data;
        if (v.par) bits[9] = ^v.data;
        n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_dv = 0; n_samp = 0;
        bad_pos = 0; edge1 = -1; edge2 = -1; dv_cyc[0] = 0; dv_cyc[1] = 0;
        @(negedge clk);
        prescale = 6'(v.p); par_en = v.par; start_glitch = v.sg;
        par_err = v.perr; stp_err = v.serr;
        rx_in = (v.glitch_len > 0) ? 1'b0 : bits[0];
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == 1) edge1 = int'(edge_cnt);
            if (k == F + 1) edge2 = int'(edge_cnt);
            if (dat_samp_en) n_samp++;
            if ((int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en)) > 1) bad_pos++;
            if (strt_chk_en) begin n_strt++; if (int'(edge_cnt) != cp) bad_pos++; end
            if (deser_en) begin
                if (int'(edge_cnt) != cp || int'(bit_cnt) != (n_deser % 8)) bad_pos++;
                n_deser++;
            end
            if (par_chk_en) begin n_par++; if (int'(edge_cnt) != cp) bad_pos++; end
            if (stp_chk_en) begin n_stp++; if (int'(edge_cnt) != cp) bad_pos++; end
            if (data_valid) begin
                if (n_dv < 2) dv_cyc[n_dv] = k;
                if (edge_cnt != 6'd0) bad_pos++;
                n_dv++;
            end
            if (v.pmid != 0 && k == 2 * v.p) begin
                prescale = 6'(v.pmid);
                par_en   = ~v.par;
            end
            if (v.glitch_len > 0)  rx_in = (k < v.glitch_len) ? 1'b0 : 1'b1;
            else if (k < nfr * F)  rx_in = bits[(k % F) / v.p];
            else                   rx_in = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t bb;
        int   quiet;
        tbl[0] = '{8,  1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 0,  1, 8, 0, 1, 1, 80,  79};
        tbl[1] = '{16, 1'b1, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 0,  1, 8, 1, 1, 1, 176, 175};
        tbl[2] = '{8,  1'b0, 8'hA5, 3, 1'b1, 1'b0, 1'b0, 0,  1, 0, 0, 0, 0, 0,   7};
        tbl[3] = '{8,  1'b1, 8'hA5, 0, 1'b0, 1'b1, 1'b0, 0,  1, 8, 1, 0, 0, 0,   79};
        tbl[4] = '{8,  1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b1, 0,  1, 8, 0, 1, 0, 0,   79};
        tbl[5] = '{32, 1'b1, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 0,  1, 8, 1, 1, 1, 352, 351};
        tbl[6] = '{8,  1'b0, 8'hC3, 0, 1'b0, 1'b0, 1'b0, 16, 1, 8, 0, 1, 1, 80,  79};
        tbl[7] = '{16, 1'b0, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 0,  1, 8, 0, 1, 1, 160, 159};

        rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        start_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                   par_chk_en, stp_chk_en, data_valid}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i], 1);
            chk($sformatf("row%0d_strt", i),  n_strt,    tbl[i].e_strt);
            chk($sformatf("row%0d_deser", i), n_deser,   tbl[i].e_deser);
            chk($sformatf("row%0d_par", i),   n_par,     tbl[i].e_par);
            chk($sformatf("row%0d_stp", i),   n_stp,     tbl[i].e_stp);
            chk($sformatf("row%0d_dv", i),    n_dv,      tbl[i].e_dv);
            chk($sformatf("row%0d_dvcyc", i), dv_cyc[0], tbl[i].e_dvcyc);
            chk($sformatf("row%0d_samp", i),  n_samp,    tbl[i].e_samp);
            chk($sformatf("row%0d_pos", i),   bad_pos,   0);
            chk($sformatf("row%0d_edge1", i), edge1,     1);
            chk($sformatf("row%0d_idle", i),  int'({edge_cnt, bit_cnt}), 0);
        end

        bb = '{32, 1'b0, 8'h81, 0, 1'b0, 1'b0, 1'b0, 0, 2, 16, 0, 2, 2, 320, 638};
        run(bb, 2);
        chk("b2b_dv",     n_dv,      2);
        chk("b2b_dv0",    dv_cyc[0], 320);
        chk("b2b_dv1",    dv_cyc[1], 640);
        chk("b2b_edge2",  edge2,     1);
        chk("b2b_strt",   n_strt,    2);
        chk("b2b_deser",  n_deser,   16);
        chk("b2b_samp",   n_samp,    638);
        chk("b2b_pos",    bad_pos,   0);

        // Reset during data bit 4 must clear everything at once and leave no residue.
        @(negedge clk);
        prescale = 6'd8; par_en = 1'b0; start_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (42) @(negedge clk);
        chk("rst_pre_bit",  int'(bit_cnt), 4);
        chk("rst_pre_samp", int'(dat_samp_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                     par_chk_en, stp_chk_en, data_valid}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            quiet += int'(dat_samp_en) + int'(deser_en) + int'(strt_chk_en) + int'(par_chk_en)
                   + int'(stp_chk_en) + int'(data_valid) + int'(edge_cnt != 6'd0);
        end
        chk("rst_post_quiet", quiet, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
